// File: rtl/dec_scan_nxm_pkg.sv
// Shared types and helpers for the registered N-line decoder with auto-scan.
package dec_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } decState_t;

    // Widest supported decode is SEL_W = 5; callers truncate to their own N.
    function automatic logic [31:0] onehot(input logic [4:0] sel);
        return 32'd1 << sel;
    endfunction

    function automatic int cntWidth(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/dec_scan_nxm_scan_tick.sv
// Prescaler for the scan mode: tick is high while the count sits at DIV-1.
module scan_tick
    import dec_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int CW = cntWidth(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (run) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/dec_scan_nxm.sv
// Registered SEL_W-to-2^SEL_W decoder with an auto-scan mode that walks the
// active line across all outputs every DIV cycles.
//
// state  | meaning
// OFF    | E = 0: all lines inactive, idx held
// DIRECT | E = 1, mode = 0: D decodes A
// SCAN   | E = 1, mode = 1: idx loaded from A on entry, then steps every DIV cycles
module dec_scan_nxm
    import dec_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int DIV        = 4,
    parameter bit ACTIVE_LOW = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   E,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       A,
    output logic [(1<<SEL_W)-1:0]  D,
    output logic [SEL_W-1:0]       idx,
    output logic                   wrap
);

    localparam int N = 1 << SEL_W;
    localparam logic [N-1:0] POL = ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};

    decState_t       stateQ, stateD;
    logic            stayScan;
    logic            tick;
    logic [SEL_W-1:0] idxNext;

    always_comb begin
        stateD = OFF;
        if (E) begin
            stateD = mode ? SCAN : DIRECT;
        end
    end

    assign stayScan = (stateD == SCAN) && (stateQ == SCAN);
    assign idxNext  = idx + 1'b1;

    scan_tick #(.DIV(DIV)) uTick (
        .clk  (clk),
        .rst  (rst),
        .clr  (!stayScan),
        .run  (stayScan),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= OFF;
            idx    <= '0;
            D      <= POL;
            wrap   <= 1'b0;
        end else begin
            stateQ <= stateD;
            wrap   <= 1'b0;
            case (stateD)
                DIRECT: begin
                    idx <= A;
                    D   <= N'(onehot(5'(A))) ^ POL;
                end
                SCAN: begin
                    if (!stayScan) begin
                        idx <= A;
                        D   <= N'(onehot(5'(A))) ^ POL;
                    end else if (tick) begin
                        idx  <= idxNext;
                        D    <= N'(onehot(5'(idxNext))) ^ POL;
                        wrap <= &idx;
                    end
                end
                default: begin
                    D <= POL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_scan_nxm.sv
// Self-checking bench: DUT 0 is SEL_W=2/DIV=4/active-high, DUT 1 is SEL_W=2/DIV=1/active-low.
module tb_dec_scan_nxm;

    logic       clk = 1'b0;
    logic       rst [2];
    logic       E   [2];
    logic       mode[2];
    logic [1:0] A   [2];
    logic [3:0] D0, D1;
    logic [1:0] idx0, idx1;
    logic       wrap0, wrap1;

    int nVec = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    dec_scan_nxm #(.SEL_W(2), .DIV(4), .ACTIVE_LOW(0)) dut0 (
        .clk(clk), .rst(rst[0]), .E(E[0]), .mode(mode[0]), .A(A[0]),
        .D(D0), .idx(idx0), .wrap(wrap0)
    );

    dec_scan_nxm #(.SEL_W(2), .DIV(1), .ACTIVE_LOW(1)) dut1 (
        .clk(clk), .rst(rst[1]), .E(E[1]), .mode(mode[1]), .A(A[1]),
        .D(D1), .idx(idx1), .wrap(wrap1)
    );

    // Reference model: "cycles spent in the current scan" rather than a prescaler.
    int divOf[2] = '{4, 1};
    bit lowOf[2] = '{1'b0, 1'b1};
    int  mIdx[2]  = '{0, 0};
    int  mCyc[2]  = '{0, 0};
    bit  mOn[2]   = '{1'b0, 1'b0};
    bit  mScan[2] = '{1'b0, 1'b0};
    bit  mWrap[2] = '{1'b0, 1'b0};

    function automatic logic [3:0] expD(input int u);
        logic [3:0] v;
        v = mOn[u] ? 4'(1 << mIdx[u]) : 4'b0000;
        return lowOf[u] ? ~v : v;
    endfunction

    task automatic stepModel(input int u);
        mWrap[u] = 1'b0;
        if (rst[u]) begin
            mIdx[u] = 0; mOn[u] = 1'b0; mScan[u] = 1'b0;
        end else if (!E[u]) begin
            mOn[u] = 1'b0; mScan[u] = 1'b0;
        end else if (!mode[u]) begin
            mOn[u] = 1'b1; mScan[u] = 1'b0; mIdx[u] = int'(A[u]);
        end else if (!mScan[u]) begin
            mOn[u] = 1'b1; mScan[u] = 1'b1; mIdx[u] = int'(A[u]); mCyc[u] = 0;
        end else begin
            mCyc[u]++;
            if (mCyc[u] == divOf[u]) begin
                mCyc[u] = 0;
                mIdx[u] = (mIdx[u] + 1) % 4;
                mWrap[u] = (mIdx[u] == 0);
            end
        end
    endtask

    task automatic checkVal(input string name, input int act, input int req);
        nVec++;
        if (act != req) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkModel();
        checkVal("d0.D",    int'(D0),    int'(expD(0)));
        checkVal("d0.idx",  int'(idx0),  mIdx[0]);
        checkVal("d0.wrap", int'(wrap0), int'(mWrap[0]));
        checkVal("d1.D",    int'(D1),    int'(expD(1)));
        checkVal("d1.idx",  int'(idx1),  mIdx[1]);
        checkVal("d1.wrap", int'(wrap1), int'(mWrap[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        stepModel(0);
        stepModel(1);
        #1;
        checkModel();
    endtask

    task automatic drive(input int u, input logic r, input logic e, input logic m, input logic [1:0] a);
        rst[u] = r; E[u] = e; mode[u] = m; A[u] = a;
    endtask

    typedef struct {
        logic       r, e, m;
        logic [1:0] a;
        logic [3:0] d;
        logic [1:0] i;
        logic       w;
    } vec_t;

    vec_t tbl[9];
    int   scanIdx[14];

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b1, 2'd3, 4'b0000, 2'd0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 2'd3, 4'b0000, 2'd0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 2'd2, 4'b0100, 2'd2, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b1000, 2'd3, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 2'd3, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 2'd0, 1'b0};
        scanIdx = '{2, 2, 2, 2, 3, 3, 3, 3, 0, 0, 0, 0, 1, 1};

        drive(0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(1, 1'b1, 1'b0, 1'b0, 2'd0);

        for (int k = 0; k < 9; k++) begin
            drive(0, tbl[k].r, tbl[k].e, tbl[k].m, tbl[k].a);
            tick();
            checkVal("tbl.D",    int'(D0),    int'(tbl[k].d));
            checkVal("tbl.idx",  int'(idx0),  int'(tbl[k].i));
            checkVal("tbl.wrap", int'(wrap0), int'(tbl[k].w));
        end
        checkVal("d1.resetD", int'(D1), 4'hF);

        // Scan from A=2 through a wrap; A changes are ignored while scanning.
        drive(0, 1'b0, 1'b1, 1'b1, 2'd2);
        for (int k = 0; k < 14; k++) begin
            tick();
            if (k == 0) A[0] = 2'd0;
            checkVal("scan.idx",  int'(idx0),  scanIdx[k]);
            checkVal("scan.D",    int'(D0),    1 << scanIdx[k]);
            checkVal("scan.wrap", int'(wrap0), (k == 8) ? 1 : 0);
        end

        // Enable drop while idx = 1, then reload from A = 3.
        E[0] = 1'b0;
        tick();
        checkVal("drop.D", int'(D0), 0);
        checkVal("drop.wrap", int'(wrap0), 0);
        drive(0, 1'b0, 1'b1, 1'b1, 2'd3);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkVal("reload.idx",  int'(idx0),  (k < 4) ? 3 : 0);
            checkVal("reload.wrap", int'(wrap0), (k == 4) ? 1 : 0);
        end

        // Mid-scan reset with the prescaler at 2, then reload from A.
        drive(0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        drive(0, 1'b0, 1'b1, 1'b1, 2'd1);
        tick(); tick(); tick();
        checkVal("pre.idx", int'(idx0), 1);
        rst[0] = 1'b1;
        tick();
        checkVal("rst.D",   int'(D0),   0);
        checkVal("rst.idx", int'(idx0), 0);
        drive(0, 1'b0, 1'b1, 1'b1, 2'd2);
        tick();
        checkVal("rel.idx", int'(idx0), 2);
        checkVal("rel.D",   int'(D0),   4'b0100);

        // DIV = 1, active-low walk from A = 0.
        drive(1, 1'b0, 1'b1, 1'b1, 2'd0);
        begin
            logic [3:0] walk[5];
            walk = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
            for (int k = 0; k < 5; k++) begin
                tick();
                checkVal("fast.D",    int'(D1),    int'(walk[k]));
                checkVal("fast.wrap", int'(wrap1), (k == 4) ? 1 : 0);
            end
        end

        // Randomized traffic on both instances, checked by the model every cycle.
        for (int k = 0; k < 400; k++) begin
            for (int u = 0; u < 2; u++) begin
                drive(u, ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) != 0),
                      ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)));
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
